// File: rtl/led_matrix_frame_scanner.sv
// 8x8 LED matrix scanner: double-buffered frame intake over valid/ready,
// tear-free swap at the frame boundary, row multiplexing with blanking gaps.
module led_matrix_frame_scanner #(
  parameter int ROW_DWELL      = 4,
  parameter int BLANK          = 2,
  parameter bit ROW_ACTIVE_LOW = 1'b0,
  parameter bit COL_ACTIVE_LOW = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_frame_valid,
  input  logic [63:0] i_frame_data,
  output logic        o_frame_ready,
  input  logic        i_oe,
  output logic [7:0]  o_rows,
  output logic [7:0]  o_columns,
  output logic        o_frame_start
);

  localparam int MaxCount = (BLANK > ROW_DWELL) ? BLANK : ROW_DWELL;
  localparam int CntW     = $clog2(MaxCount) + 1;
  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK - 1);
  localparam logic [CntW-1:0] DwellLast = CntW'(ROW_DWELL - 1);

  typedef enum logic {StBlank, StOn} state_e;

  state_e            state_q, state_d;
  logic [2:0]        row_q, row_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [63:0]       display_q, display_d;
  logic [63:0]       pending_q, pending_d;
  logic              pendingFull_q, pendingFull_d;
  logic [7:0]        rows_q, rows_d;
  logic [7:0]        cols_q, cols_d;
  logic              frameStart_q, frameStart_d;
  logic              take;

  assign o_frame_ready = ~pendingFull_q & ~rst;
  assign take          = i_frame_valid & o_frame_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StBlank;
      row_q         <= '0;
      cnt_q         <= '0;
      display_q     <= '0;
      pending_q     <= '0;
      pendingFull_q <= 1'b0;
      rows_q        <= '0;
      cols_q        <= '0;
      frameStart_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      cnt_q         <= cnt_d;
      display_q     <= display_d;
      pending_q     <= pending_d;
      pendingFull_q <= pendingFull_d;
      rows_q        <= rows_d;
      cols_q        <= cols_d;
      frameStart_q  <= frameStart_d;
    end
  end

  // Swap happens only when leaving row 7, so a half-drawn frame is never mixed with a new one.
  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    cnt_d         = cnt_q + 1'b1;
    display_d     = display_q;
    pending_d     = pending_q;
    pendingFull_d = pendingFull_q;
    frameStart_d  = 1'b0;

    case (state_q)
      StBlank: begin
        if (cnt_q == BlankLast) begin
          state_d = StOn;
          cnt_d   = '0;
        end
      end
      StOn: begin
        if (cnt_q == DwellLast) begin
          state_d = StBlank;
          cnt_d   = '0;
          row_d   = row_q + 3'd1;
          if (row_q == 3'd7) begin
            frameStart_d = 1'b1;
            if (pendingFull_q) begin
              display_d     = pending_q;
              pendingFull_d = 1'b0;
            end
          end
        end
      end
      default: begin
        state_d = StBlank;
        cnt_d   = '0;
      end
    endcase

    if (take) begin
      pending_d     = i_frame_data;
      pendingFull_d = 1'b1;
    end
  end

  always_comb begin
    rows_d = '0;
    cols_d = '0;
    if (state_q == StOn && i_oe) begin
      rows_d = 8'h01 << row_q;
      cols_d = display_q[{row_q, 3'b000} +: 8];
    end
  end

  assign o_rows        = rows_q ^ {8{ROW_ACTIVE_LOW}};
  assign o_columns     = cols_q ^ {8{COL_ACTIVE_LOW}};
  assign o_frame_start = frameStart_q;

endmodule

// File: tb/tb_led_matrix_frame_scanner.sv
// Bench for led_matrix_frame_scanner: phase-arithmetic reference model checked every
// cycle on both an active-high and an active-low instance, plus pinned literal checks.
module tb_led_matrix_frame_scanner;

  localparam int RowDwell    = 4;
  localparam int BlankCycles = 2;
  localparam int RowPeriod   = RowDwell + BlankCycles;
  localparam int FramePeriod = 8 * RowPeriod;

  localparam logic [63:0] FrameDiag = 64'h8040201008040201;
  localparam logic [63:0] FrameA    = 64'h0123456789ABCDEF;
  localparam logic [63:0] FrameB    = 64'hFEDCBA9876543210;
  localparam logic [63:0] FrameC    = 64'hA5A5A5A5A5A5A5A5;
  localparam logic [63:0] FrameLow  = 64'h00000000000000FF;

  logic        clk;
  logic        rst;
  logic        frameValid;
  logic [63:0] frameData;
  logic        oe;
  logic        ready, readyL;
  logic [7:0]  rows, rowsL, cols, colsL;
  logic        frameStart, frameStartL;

  int nChecks = 0;
  int nFails  = 0;
  bit checkEn = 1'b0;

  // Model state: cycle index since reset release and the two frame buffers.
  int          mt;
  bit          mPendFull;
  logic [63:0] mPending, mDisplay;
  logic [7:0]  expRows, expCols;
  logic        expStart;

  led_matrix_frame_scanner #(
    .ROW_DWELL(RowDwell), .BLANK(BlankCycles), .ROW_ACTIVE_LOW(1'b0), .COL_ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .i_frame_valid(frameValid), .i_frame_data(frameData),
    .o_frame_ready(ready), .i_oe(oe), .o_rows(rows), .o_columns(cols),
    .o_frame_start(frameStart)
  );

  led_matrix_frame_scanner #(
    .ROW_DWELL(RowDwell), .BLANK(BlankCycles), .ROW_ACTIVE_LOW(1'b1), .COL_ACTIVE_LOW(1'b1)
  ) dutLow (
    .clk(clk), .rst(rst), .i_frame_valid(frameValid), .i_frame_data(frameData),
    .o_frame_ready(readyL), .i_oe(oe), .o_rows(rowsL), .o_columns(colsL),
    .o_frame_start(frameStartL)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0d)", name, actual, expected, mt);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [63:0] data, input logic enable);
    frameValid = valid;
    frameData  = data;
    oe         = enable;
  endtask

  task automatic toCycle(input int k);
    int guard = 0;
    while (mt < k && guard < 500) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (mt < k) begin
      nChecks++;
      nFails++;
      $display("[TB] FAIL toCycle: reached %0d, expected %0d", mt, k);
    end
  endtask

  task automatic atCycle(input int k);
    toCycle(k);
    @(negedge clk);
  endtask

  // Reference: position in the frame comes from plain modular arithmetic on the cycle index.
  always @(posedge clk) begin
    int  phase, row;
    bit  lit, take;
    if (rst) begin
      mt        = 0;
      mPendFull = 1'b0;
      mPending  = '0;
      mDisplay  = '0;
      expRows   = '0;
      expCols   = '0;
      expStart  = 1'b0;
    end else begin
      phase   = mt % FramePeriod;
      row     = phase / RowPeriod;
      lit     = ((phase % RowPeriod) >= BlankCycles) && oe;
      expRows = lit ? (8'h01 << row) : 8'h00;
      expCols = lit ? mDisplay[8*row +: 8] : 8'h00;
      take    = frameValid && !mPendFull;
      mt++;
      expStart = (mt % FramePeriod) == 0;
      if (expStart && mPendFull) begin
        mDisplay  = mPending;
        mPendFull = 1'b0;
      end
      if (take) begin
        mPending  = frameData;
        mPendFull = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    logic expReady;
    if (checkEn) begin
      expReady = !mPendFull && !rst;
      checkOutput("modelRows", rows, expRows);
      checkOutput("modelCols", cols, expCols);
      checkOutput("modelStart", {7'd0, frameStart}, {7'd0, expStart});
      checkOutput("modelReady", {7'd0, ready}, {7'd0, expReady});
      checkOutput("modelRowsLow", rowsL, expRows ^ 8'hFF);
      checkOutput("modelColsLow", colsL, expCols ^ 8'hFF);
      checkOutput("modelStartLow", {7'd0, frameStartL}, {7'd0, expStart});
      checkOutput("modelReadyLow", {7'd0, readyL}, {7'd0, expReady});
    end
  end

  initial begin
    rst = 1'b1;
    mt  = 0;
    applyStimulus(1'b0, 64'd0, 1'b1);
    @(posedge clk);
    #1 checkEn = 1'b1;
    @(negedge clk);
    checkOutput("resetReady", {7'd0, ready}, 8'h00);
    checkOutput("resetRows", rows, 8'h00);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // Free-running scan over a blank display.
    atCycle(0);
    checkOutput("idleRows", rows, 8'h00);
    checkOutput("idleReady", {7'd0, ready}, 8'h01);
    checkOutput("idleRowsLow", rowsL, 8'hFF);
    checkOutput("idleColsLow", colsL, 8'hFF);
    atCycle(3);  checkOutput("row0Lit", rows, 8'h01);
    atCycle(7);  checkOutput("row0Blank", rows, 8'h00);
    atCycle(9);  checkOutput("row1Lit", rows, 8'h02);
    atCycle(45); checkOutput("row7Lit", rows, 8'h80);
    atCycle(48); checkOutput("firstStart", {7'd0, frameStart}, 8'h01);

    // Single diagonal frame.
    toCycle(50); applyStimulus(1'b1, FrameDiag, 1'b1);
    toCycle(51); applyStimulus(1'b0, 64'd0, 1'b1);
    @(negedge clk); checkOutput("diagAccepted", {7'd0, ready}, 8'h00);
    atCycle(57);  checkOutput("diagNotYet", cols, 8'h00);
    atCycle(96);  checkOutput("diagStart", {7'd0, frameStart}, 8'h01);
    checkOutput("diagReadyBack", {7'd0, ready}, 8'h01);
    atCycle(99);  checkOutput("diagRow0", cols, 8'h01);
    atCycle(117); checkOutput("diagRow3Rows", rows, 8'h08);
    checkOutput("diagRow3Cols", cols, 8'h08);

    // Back-to-back frames with valid held.
    toCycle(120); applyStimulus(1'b1, FrameA, 1'b1);
    toCycle(121); applyStimulus(1'b1, FrameB, 1'b1);
    atCycle(130); checkOutput("bStalled", {7'd0, ready}, 8'h00);
    atCycle(144); checkOutput("bReadyAtSwap", {7'd0, ready}, 8'h01);
    toCycle(145); applyStimulus(1'b0, 64'd0, 1'b1);
    @(negedge clk); checkOutput("bAccepted", {7'd0, ready}, 8'h00);
    atCycle(147); checkOutput("showA", cols, 8'hEF);
    atCycle(195); checkOutput("showB", cols, 8'h10);
    atCycle(207); checkOutput("showBRow2Rows", rows, 8'h04);
    checkOutput("showBRow2Cols", cols, 8'h54);

    // Output enable dropped during row 3.
    toCycle(261); applyStimulus(1'b0, 64'd0, 1'b0);
    @(negedge clk); checkOutput("oeRow3Lit", rows, 8'h08);
    atCycle(262); checkOutput("oeBlankRows", rows, 8'h00);
    checkOutput("oeBlankCols", cols, 8'h00);
    toCycle(264); applyStimulus(1'b0, 64'd0, 1'b1);
    atCycle(266); checkOutput("oeGap", rows, 8'h00);
    atCycle(267); checkOutput("oeRow4Rows", rows, 8'h10);
    checkOutput("oeRow4Cols", cols, 8'h98);

    // Reset mid-row with a pending frame.
    toCycle(290); applyStimulus(1'b1, FrameC, 1'b1);
    toCycle(291); applyStimulus(1'b0, 64'd0, 1'b1);
    toCycle(321); rst = 1'b1;
    @(negedge clk); checkOutput("rstRow5Lit", rows, 8'h20);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("rstBlankRows", rows, 8'h00);
    checkOutput("rstBlankCols", cols, 8'h00);
    checkOutput("rstReady", {7'd0, ready}, 8'h00);
    @(posedge clk); #1 rst = 1'b0;
    atCycle(0); checkOutput("rstPendingGone", {7'd0, ready}, 8'h01);
    atCycle(3); checkOutput("rstRow0Rows", rows, 8'h01);
    checkOutput("rstRow0Cols", cols, 8'h00);

    // Polarity of the active-low instance with a full first row.
    toCycle(10); applyStimulus(1'b1, FrameLow, 1'b1);
    toCycle(11); applyStimulus(1'b0, 64'd0, 1'b1);
    atCycle(48); checkOutput("lowStart", {7'd0, frameStartL}, 8'h01);
    atCycle(51);
    checkOutput("lowRowsHigh", rows, 8'h01);
    checkOutput("lowColsHigh", cols, 8'hFF);
    checkOutput("lowRows", rowsL, 8'hFE);
    checkOutput("lowCols", colsL, 8'h00);

    @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
